// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for one 3-to-8 decoded resource select shared by 8 requesters.
// Grants are held while the requester keeps req high, up to MAX_HOLD cycles.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant; arbitrate req starting at ptr (break-before-make gap)
// GRANT | gnt_idx owns the select; counting held cycles in hold_cnt
module decoder_rr_arbiter #(
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] req,
   output logic       gnt_valid,
   output logic [2:0] gnt_idx,
   output logic [7:0] gnt,
   output logic       timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

   state_t            state, state_nxt;
   logic [2:0]        ptr, ptr_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic [2:0]        idx_nxt;
   logic              valid_nxt;
   logic [7:0]        gnt_nxt;
   logic              timeout_nxt;
   logic [2:0]        pick;
   logic [2:0]        cand;
   logic              found;

   // First set request bit scanning ptr, ptr+1, ... with 3-bit wrap.
   always_comb begin
      pick  = ptr;
      cand  = ptr;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cand = ptr + 3'(i);
         if (!found && req[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      idx_nxt     = gnt_idx;
      valid_nxt   = gnt_valid;
      ptr_nxt     = ptr;
      hold_nxt    = hold_cnt;
      timeout_nxt = 1'b0;
      case (state)
         IDLE: begin
            valid_nxt = 1'b0;
            if (found) begin
               idx_nxt   = pick;
               valid_nxt = 1'b1;
               hold_nxt  = HOLD_W'(1);
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (!req[gnt_idx]) begin
               valid_nxt = 1'b0;
               ptr_nxt   = gnt_idx + 3'd1;
               state_nxt = IDLE;
            end else if (hold_cnt == HOLD_MAX) begin
               valid_nxt   = 1'b0;
               ptr_nxt     = gnt_idx + 3'd1;
               timeout_nxt = 1'b1;
               state_nxt   = IDLE;
            end else begin
               hold_nxt = hold_cnt + HOLD_W'(1);
            end
         end
         default: begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
         end
      endcase
      // Registered one-hot keeps the decoder select glitch-free and independent of req.
      gnt_nxt = valid_nxt ? (8'b0000_0001 << idx_nxt) : 8'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         gnt_valid <= 1'b0;
         gnt_idx   <= 3'd0;
         gnt       <= 8'b0;
         timeout   <= 1'b0;
         ptr       <= 3'd0;
         hold_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         gnt_valid <= valid_nxt;
         gnt_idx   <= idx_nxt;
         gnt       <= gnt_nxt;
         timeout   <= timeout_nxt;
         ptr       <= ptr_nxt;
         hold_cnt  <= hold_nxt;
      end
   end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter: three instances with hold limits 16, 4 and 1.
module tb_decoder_rr_arbiter;

   logic       clk;
   logic       reset;
   logic [7:0] req, req4, req1;
   logic       valid, valid4, valid1;
   logic [2:0] idx, idx4, idx1;
   logic [7:0] gnt, gnt4, gnt1;
   logic       tmo, tmo4, tmo1;

   int total = 0;
   int bad   = 0;

   decoder_rr_arbiter #(.MAX_HOLD(16), .HOLD_W(5)) dut (
      .clk(clk), .reset(reset), .req(req),
      .gnt_valid(valid), .gnt_idx(idx), .gnt(gnt), .timeout(tmo));

   decoder_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(5)) dut4 (
      .clk(clk), .reset(reset), .req(req4),
      .gnt_valid(valid4), .gnt_idx(idx4), .gnt(gnt4), .timeout(tmo4));

   decoder_rr_arbiter #(.MAX_HOLD(1), .HOLD_W(5)) dut1 (
      .clk(clk), .reset(reset), .req(req1),
      .gnt_valid(valid1), .gnt_idx(idx1), .gnt(gnt1), .timeout(tmo1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req   = 8'hFF;
      repeat (3) step();
      total++;
      if ({valid, idx, gnt, tmo} !== 13'd0) begin
         bad++;
         $display("FAIL reset_outputs got valid=%b idx=%0d gnt=%b tmo=%b want all 0", valid, idx, gnt, tmo);
      end
      reset = 1'b1;
      step();
      total++;
      if (valid !== 1'b1 || idx !== 3'd0 || gnt !== 8'b0000_0001) begin
         bad++;
         $display("FAIL first_grant got valid=%b idx=%0d gnt=%b want 1/0/00000001", valid, idx, gnt);
      end
      req = 8'h00;
      step();
      total++;
      if (valid !== 1'b0 || gnt !== 8'h00 || tmo !== 1'b0 || idx !== 3'd0) begin
         bad++;
         $display("FAIL release_idle got valid=%b gnt=%b tmo=%b idx=%0d want 0/0/0/0", valid, gnt, tmo, idx);
      end
   endtask

   // ptr is 1 on entry.
   task automatic test_normal_release();
      req = 8'b0010_0000;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (valid !== 1'b1 || gnt !== 8'b0010_0000 || idx !== 3'd5 || tmo !== 1'b0) begin
            bad++;
            $display("FAIL hold5_cycle%0d got valid=%b idx=%0d gnt=%b tmo=%b want 1/5/00100000/0", i, valid, idx, gnt, tmo);
         end
      end
      req = 8'h00;
      step();
      total++;
      if (valid !== 1'b0 || gnt !== 8'h00 || tmo !== 1'b0) begin
         bad++;
         $display("FAIL release5 got valid=%b gnt=%b tmo=%b want 0/0/0", valid, gnt, tmo);
      end
      req = 8'hFF;
      step();
      total++;
      if (valid !== 1'b1 || idx !== 3'd6 || gnt !== 8'b0100_0000) begin
         bad++;
         $display("FAIL next_after5 got valid=%b idx=%0d gnt=%b want 1/6/01000000", valid, idx, gnt);
      end
      req = 8'h00;
      step();
   endtask

   task automatic test_wrap();
      reset = 1'b0;
      step();
      reset = 1'b1;
      req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         logic [2:0] e;
         e = 3'(k % 8);
         step();
         total++;
         if (valid !== 1'b1 || idx !== e || gnt !== (8'b0000_0001 << e)) begin
            bad++;
            $display("FAIL wrap_grant%0d got valid=%b idx=%0d gnt=%b want idx %0d", k, valid, idx, gnt, e);
         end
         req = 8'hFF & ~(8'b0000_0001 << e);
         step();
         total++;
         if (valid !== 1'b0 || gnt !== 8'h00) begin
            bad++;
            $display("FAIL wrap_gap%0d got valid=%b gnt=%b want 0/0", k, valid, gnt);
         end
         req = 8'hFF;
      end
      req = 8'h00;
      step();
   endtask

   task automatic test_async_reset();
      req = 8'b0000_1000;
      step();
      step();
      total++;
      if (valid !== 1'b1 || idx !== 3'd3 || gnt !== 8'b0000_1000) begin
         bad++;
         $display("FAIL pre_reset_grant got valid=%b idx=%0d gnt=%b want 1/3/00001000", valid, idx, gnt);
      end
      #2;
      reset = 1'b0;
      #1;
      total++;
      if ({valid, idx, gnt, tmo} !== 13'd0) begin
         bad++;
         $display("FAIL async_reset got valid=%b idx=%0d gnt=%b tmo=%b want all 0", valid, idx, gnt, tmo);
      end
      step();
      reset = 1'b1;
      req = 8'b0010_1000;
      step();
      total++;
      if (valid !== 1'b1 || idx !== 3'd3 || gnt !== 8'b0000_1000) begin
         bad++;
         $display("FAIL ptr_restart got valid=%b idx=%0d gnt=%b want 1/3/00001000", valid, idx, gnt);
      end
      req = 8'h00;
      step();
   endtask

   task automatic test_hold_limit();
      logic [2:0] seq [4];
      seq[0] = 3'd0; seq[1] = 3'd7; seq[2] = 3'd0; seq[3] = 3'd7;
      req4 = 8'b1000_0001;
      for (int g = 0; g < 4; g++) begin
         for (int c = 0; c < 4; c++) begin
            step();
            total++;
            if (valid4 !== 1'b1 || idx4 !== seq[g] || gnt4 !== (8'b0000_0001 << seq[g]) || tmo4 !== 1'b0) begin
               bad++;
               $display("FAIL hold4_g%0d_c%0d got valid=%b idx=%0d gnt=%b tmo=%b want idx %0d tmo 0", g, c, valid4, idx4, gnt4, tmo4, seq[g]);
            end
         end
         step();
         total++;
         if (valid4 !== 1'b0 || gnt4 !== 8'h00 || tmo4 !== 1'b1) begin
            bad++;
            $display("FAIL hold4_idle%0d got valid=%b gnt=%b tmo=%b want 0/0/1", g, valid4, gnt4, tmo4);
         end
      end
      req4 = 8'h00;
      step();
      total++;
      if (valid4 !== 1'b0 || tmo4 !== 1'b0) begin
         bad++;
         $display("FAIL hold4_quiet got valid=%b tmo=%b want 0/0", valid4, tmo4);
      end
   endtask

   task automatic test_back_to_back();
      req1 = 8'b0000_0100;
      for (int r = 0; r < 3; r++) begin
         step();
         total++;
         if (valid1 !== 1'b1 || idx1 !== 3'd2 || gnt1 !== 8'b0000_0100 || tmo1 !== 1'b0) begin
            bad++;
            $display("FAIL hold1_grant%0d got valid=%b idx=%0d gnt=%b tmo=%b want 1/2/00000100/0", r, valid1, idx1, gnt1, tmo1);
         end
         step();
         total++;
         if (valid1 !== 1'b0 || gnt1 !== 8'h00 || tmo1 !== 1'b1) begin
            bad++;
            $display("FAIL hold1_idle%0d got valid=%b gnt=%b tmo=%b want 0/0/1", r, valid1, gnt1, tmo1);
         end
      end
      // Request drop at the hold limit is a normal release: no timeout.
      step();
      req1 = 8'h00;
      step();
      total++;
      if (valid1 !== 1'b0 || tmo1 !== 1'b0) begin
         bad++;
         $display("FAIL hold1_drop got valid=%b tmo=%b want 0/0", valid1, tmo1);
      end
   endtask

   initial begin
      req  = 8'h00;
      req4 = 8'h00;
      req1 = 8'h00;
      test_reset();
      test_normal_release();
      test_wrap();
      test_async_reset();
      test_hold_limit();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
